exstatus: RTL and testbench

Parametrised idle/status word inserter for the exbus transmit path, placed between the bus-response compressor and the word-to-byte framer. Passes data words through with priority and fills gaps with status words carrying AUX lines, CTS, interrupt and FIFO-error state, plus periodic idles. Compared with the single-width, fixed-field generation, it adds configurable word and AUX widths, a programmable sync burst, an error-report rate limiter with a saturating drop count, and packet-aware insertion: status words never split a multi-word packet.

---
 rtl/exstatus.sv | 229 ++++++++++++++++++++++
 tb/tb_exstatus.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/exstatus.sv
// Idle/status word inserter for the exbus transmit path: data words pass with
// priority, gaps are filled with status, error-report and periodic idle words.
module exstatus #(
  parameter int unsigned DW           = 35,
  parameter int unsigned NAUX         = 2,
  parameter bit          OPT_IDLE     = 1'b1,
  parameter int unsigned SHORT_LGIDLE = 15,
  parameter int unsigned LGIDLE       = 23,
  parameter int unsigned NSYNC        = 8,
  parameter int unsigned LGHOLDOFF    = 20
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_stb,
  input  logic [DW-1:0]   i_word,
  input  logic            i_last,
  output logic            o_busy,
  input  logic [NAUX-1:0] i_aux,
  input  logic            i_cts,
  input  logic            i_int,
  input  logic            i_fifo_err,
  output logic            o_stb,
  output logic [DW-1:0]   o_word,
  output logic            o_last,
  input  logic            i_busy,
  output logic [7:0]      o_err_drops
);

  localparam int unsigned       TW       = LGIDLE + 1;
  localparam logic [TW-1:0]     SHORT_IV = TW'(1) << SHORT_LGIDLE;
  localparam logic [TW-1:0]     LONG_IV  = TW'(1) << LGIDLE;
  localparam logic [7:0]        NSYNC_C  = 8'(NSYNC);
  localparam logic [2:0]        CODE_ERR = 3'b011;

  typedef enum logic [1:0] {
    K_NONE,
    K_DATA,
    K_STATUS,
    K_ERR
  } kind_e;

  logic                 stb_q, stb_d;
  logic [DW-1:0]        word_q, word_d;
  logic                 last_q, last_d;
  kind_e                kind_q, kind_d;
  kind_e                sel;

  logic                 inpkt_q, inpkt_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [LGHOLDOFF-1:0] holdoff_q, holdoff_d;
  logic [7:0]           sync_q, sync_d;
  logic [7:0]           drops_q, drops_d;

  logic                 err_q, err_d;
  logic                 int_q, int_d;
  logic                 cts_q, cts_d;
  logic                 aux_q, aux_d;

  logic                 int_prev_q, err_prev_q;
  logic [NAUX-1:0]      aux_prev_q;
  logic                 aux_valid_q;

  logic                 free, out_take, clr_status, clr_err;
  logic                 int_rise, err_rise, aux_change;
  logic                 int_eff, cts_eff, aux_eff;
  logic                 err_ok, status_ok, timeout;
  logic [TW-1:0]        interval;
  logic [DW-1:0]        data_word;

  function automatic logic [DW-1:0] special_word(input logic [NAUX-1:0] aux,
                                                 input logic [2:0]      code);
    logic [DW-1:0] w;
    w                  = '0;
    w[DW-1 -: 2]       = 2'b11;
    w[DW-3 -: NAUX]    = aux;
    w[DW-3-NAUX -: 3]  = code;
    return w;
  endfunction

  assign o_stb       = stb_q;
  assign o_word      = word_q;
  assign o_last      = last_q;
  assign o_busy      = stb_q && i_busy;
  assign o_err_drops = drops_q;

  assign free       = !stb_q || !i_busy;
  assign out_take   = stb_q && !i_busy;
  assign clr_status = out_take && (kind_q == K_STATUS);
  assign clr_err    = out_take && (kind_q == K_ERR);

  assign int_rise   = i_int && !int_prev_q;
  assign err_rise   = i_fifo_err && !err_prev_q;
  // The first cycle after reset only primes the AUX history, so the initial
  // line state is not mistaken for a change.
  assign aux_change = aux_valid_q && (i_aux != aux_prev_q);

  // Flags already on their way out this cycle must not trigger a duplicate word.
  assign int_eff = int_q && !clr_status;
  assign cts_eff = cts_q && !clr_status;
  assign aux_eff = aux_q && !clr_status;

  assign interval  = (sync_q < NSYNC_C) ? SHORT_IV : LONG_IV;
  assign timeout   = OPT_IDLE && (timer_q >= interval);
  assign err_ok    = err_q && !clr_err && (holdoff_q == '0);
  assign status_ok = int_eff || cts_eff || aux_eff || timeout;

  always_comb begin
    data_word = i_word;
    if (i_word[DW-1 -: 2] == 2'b11) begin
      data_word[DW-3 -: NAUX] = i_aux;
    end
  end

  // Output slot selection and loading.
  always_comb begin
    stb_d  = stb_q;
    word_d = word_q;
    last_d = last_q;
    kind_d = kind_q;
    sel    = K_NONE;
    if (free) begin
      if (i_stb) begin
        sel = K_DATA;
      end else if (!inpkt_q && err_ok) begin
        sel = K_ERR;
      end else if (!inpkt_q && status_ok) begin
        sel = K_STATUS;
      end
      kind_d = sel;
      stb_d  = (sel != K_NONE);
      case (sel)
        K_DATA: begin
          word_d = data_word;
          last_d = i_last;
        end
        K_ERR: begin
          word_d = special_word(i_aux, CODE_ERR);
          last_d = 1'b1;
        end
        K_STATUS: begin
          word_d = special_word(i_aux, {1'b1, !cts_eff, int_eff});
          last_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Packet tracking, timers, flags and drop counter.
  always_comb begin
    inpkt_d   = inpkt_q;
    timer_d   = timer_q;
    holdoff_d = holdoff_q;
    sync_d    = sync_q;
    drops_d   = drops_q;

    if (sel == K_DATA) begin
      inpkt_d = !i_last;
    end

    if (sel != K_NONE) begin
      timer_d = '0;
    end else if (OPT_IDLE && !inpkt_q && (timer_q < interval)) begin
      timer_d = timer_q + TW'(1);
    end

    if (sel == K_ERR) begin
      holdoff_d = '1;
    end else if (holdoff_q != '0) begin
      holdoff_d = holdoff_q - LGHOLDOFF'(1);
    end

    if (sel == K_DATA) begin
      sync_d = '0;
    end else if ((sel == K_STATUS) && timeout && (sync_q < NSYNC_C)) begin
      sync_d = sync_q + 8'd1;
    end

    if (err_rise && err_q && (drops_q != 8'hFF)) begin
      drops_d = drops_q + 8'd1;
    end

    err_d = (err_q && !clr_err) || err_rise;
    int_d = int_eff || int_rise;
    cts_d = cts_eff || !i_cts;
    aux_d = aux_eff || aux_change;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      stb_q       <= 1'b0;
      word_q      <= '0;
      last_q      <= 1'b0;
      kind_q      <= K_NONE;
      inpkt_q     <= 1'b0;
      timer_q     <= '0;
      holdoff_q   <= '0;
      sync_q      <= '0;
      drops_q     <= '0;
      err_q       <= 1'b0;
      int_q       <= 1'b0;
      cts_q       <= 1'b0;
      aux_q       <= 1'b0;
      int_prev_q  <= 1'b0;
      err_prev_q  <= 1'b0;
      aux_prev_q  <= '0;
      aux_valid_q <= 1'b0;
    end else begin
      stb_q       <= stb_d;
      word_q      <= word_d;
      last_q      <= last_d;
      kind_q      <= kind_d;
      inpkt_q     <= inpkt_d;
      timer_q     <= timer_d;
      holdoff_q   <= holdoff_d;
      sync_q      <= sync_d;
      drops_q     <= drops_d;
      err_q       <= err_d;
      int_q       <= int_d;
      cts_q       <= cts_d;
      aux_q       <= aux_d;
      int_prev_q  <= i_int;
      err_prev_q  <= i_fifo_err;
      aux_prev_q  <= i_aux;
      aux_valid_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_exstatus.sv
// Directed bench for exstatus: idle sync burst, data priority, packet guard,
// error holdoff, stall hold and asynchronous reset.
module tb_exstatus;

  localparam int unsigned DW = 35;

  logic          clk = 1'b0;
  logic          i_reset;
  logic          i_stb;
  logic [DW-1:0] i_word;
  logic          i_last;
  logic          o_busy;
  logic [1:0]    i_aux;
  logic          i_cts;
  logic          i_int;
  logic          i_fifo_err;
  logic          o_stb;
  logic [DW-1:0] o_word;
  logic          o_last;
  logic          i_busy;
  logic [7:0]    o_err_drops;

  always #5 clk = ~clk;

  exstatus #(
    .DW          (35),
    .NAUX        (2),
    .OPT_IDLE    (1'b1),
    .SHORT_LGIDLE(4),
    .LGIDLE      (8),
    .NSYNC       (8),
    .LGHOLDOFF   (6)
  ) dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_stb      (i_stb),
    .i_word     (i_word),
    .i_last     (i_last),
    .o_busy     (o_busy),
    .i_aux      (i_aux),
    .i_cts      (i_cts),
    .i_int      (i_int),
    .i_fifo_err (i_fifo_err),
    .o_stb      (o_stb),
    .o_word     (o_word),
    .o_last     (o_last),
    .i_busy     (i_busy),
    .o_err_drops(o_err_drops)
  );

  localparam logic [DW-1:0] IDLE_W = {2'b11, 2'b01, 3'b110, 28'd0};
  localparam logic [DW-1:0] ERR_W  = {2'b11, 2'b01, 3'b011, 28'd0};
  localparam logic [DW-1:0] D_IN   = {2'b11, 2'b10, 31'h0ABC_DEF1};
  localparam logic [DW-1:0] D_EXP  = {2'b11, 2'b01, 31'h0ABC_DEF1};
  localparam logic [DW-1:0] PKT_W1 = {2'b00, 33'h1_2345_6789};
  localparam logic [DW-1:0] PKT_W2 = {2'b01, 33'h0_0F0F_0F0F};
  localparam logic [DW-1:0] PKT_W3 = {2'b10, 33'h1_DEAD_BEEF};

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    i_reset = 1'b0;
  endtask

  initial begin
    int pos[10];
    int np;
    int found;
    int mid;
    int epos[4];
    int ne;

    i_reset    = 1'b1;
    i_stb      = 1'b0;
    i_word     = '0;
    i_last     = 1'b0;
    i_aux      = 2'b01;
    i_cts      = 1'b1;
    i_int      = 1'b0;
    i_fifo_err = 1'b0;
    i_busy     = 1'b0;

    #1;
    check_eq("rst_stb",   64'(o_stb),       64'd0);
    check_eq("rst_word",  64'(o_word),      64'd0);
    check_eq("rst_last",  64'(o_last),      64'd0);
    check_eq("rst_drops", 64'(o_err_drops), 64'd0);
    @(negedge clk);
    @(negedge clk);
    i_reset = 1'b0;

    // Idle sync burst: 8 short-interval idles, then long interval.
    for (int i = 0; i < 10; i++) pos[i] = 0;
    np = 0;
    for (int k = 1; k <= 700; k++) begin
      @(posedge clk); #1;
      if (o_stb && np < 10) begin
        if (np == 0) begin
          check_eq("idle_word", 64'(o_word), 64'(IDLE_W));
          check_eq("idle_last", 64'(o_last), 64'd1);
        end
        pos[np] = k;
        np++;
      end
    end
    check_eq("idle_first_edge", 64'(pos[0]), 64'd17);
    for (int i = 1; i < 8; i++) check_eq("idle_short_gap", 64'(pos[i] - pos[i-1]), 64'd17);
    for (int i = 8; i < 10; i++) check_eq("idle_long_gap", 64'(pos[i] - pos[i-1]), 64'd257);

    // Data arriving on the same edge the first idle timeout fires.
    do_reset();
    mid = 0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      if (o_stb) mid++;
    end
    check_eq("pre_data_quiet", 64'(mid), 64'd0);
    i_stb  = 1'b1;
    i_word = D_IN;
    i_last = 1'b1;
    @(posedge clk); #1;
    check_eq("data_stb",  64'(o_stb),  64'd1);
    check_eq("data_word", 64'(o_word), 64'(D_EXP));
    check_eq("data_last", 64'(o_last), 64'd1);
    i_stb = 1'b0;
    found = 0;
    for (int k = 1; k <= 40 && found == 0; k++) begin
      @(posedge clk); #1;
      if (o_stb) found = k;
    end
    check_eq("idle_after_data_gap",  64'(found),  64'd17);
    check_eq("idle_after_data_word", 64'(o_word), 64'(IDLE_W));

    // Packet guard with an interrupt arriving mid-packet.
    i_stb  = 1'b1;
    i_word = PKT_W1;
    i_last = 1'b0;
    @(posedge clk); #1;
    check_eq("pkt_w1",      64'(o_word), 64'(PKT_W1));
    check_eq("pkt_w1_last", 64'(o_last), 64'd0);
    i_stb = 1'b0;
    mid = 0;
    for (int g = 0; g < 20; g++) begin
      i_int = (g == 4);
      @(posedge clk); #1;
      if (o_stb) mid++;
    end
    i_int = 1'b0;
    check_eq("pkt_gap_quiet", 64'(mid), 64'd0);
    i_stb  = 1'b1;
    i_word = PKT_W2;
    @(posedge clk); #1;
    check_eq("pkt_w2", 64'(o_word), 64'(PKT_W2));
    i_word = PKT_W3;
    i_last = 1'b1;
    @(posedge clk); #1;
    check_eq("pkt_w3",      64'(o_word), 64'(PKT_W3));
    check_eq("pkt_w3_last", 64'(o_last), 64'd1);
    i_stb  = 1'b0;
    i_last = 1'b0;
    @(posedge clk); #1;
    check_eq("int_stat_stb",  64'(o_stb),              64'd1);
    check_eq("int_stat_type", 64'(o_word[34:33]),      64'd3);
    check_eq("int_stat_code", 64'({o_word[30], o_word[28]}), 64'd3);
    check_eq("int_stat_last", 64'(o_last),             64'd1);
    @(posedge clk); #1;
    check_eq("int_stat_once", 64'(o_stb), 64'd0);

    // Error holdoff: four pulses, five cycles apart.
    for (int i = 0; i < 4; i++) epos[i] = 0;
    ne = 0;
    for (int k = 0; k < 100; k++) begin
      i_fifo_err = (k == 0) || (k == 5) || (k == 10) || (k == 15);
      @(posedge clk); #1;
      if (o_stb && o_word[34:33] == 2'b11 && o_word[30:28] == 3'b011) begin
        if (ne == 0) check_eq("err_word", 64'(o_word), 64'(ERR_W));
        if (ne < 4) epos[ne] = k;
        ne++;
      end
    end
    i_fifo_err = 1'b0;
    check_eq("err_count",  64'(ne),                 64'd2);
    check_eq("err_first",  64'(epos[0]),            64'd1);
    check_eq("err_gap",    64'(epos[1] - epos[0]),  64'd64);
    check_eq("err_drops",  64'(o_err_drops),        64'd2);

    // Stall: hold an idle word for 10 cycles, offered data must not enter.
    found = 0;
    for (int k = 1; k <= 300 && found == 0; k++) begin
      @(posedge clk); #1;
      if (o_stb) found = k;
    end
    check_eq("stall_found", 64'(found != 0), 64'd1);
    i_busy = 1'b1;
    i_stb  = 1'b1;
    i_word = PKT_W1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check_eq("stall_stb",  64'(o_stb),  64'd1);
      check_eq("stall_busy", 64'(o_busy), 64'd1);
      check_eq("stall_word", 64'(o_word), 64'(IDLE_W));
    end

    // Asynchronous reset in the middle of the stall.
    #3;
    i_reset = 1'b1;
    #1;
    check_eq("arst_stb",   64'(o_stb),       64'd0);
    check_eq("arst_word",  64'(o_word),      64'd0);
    check_eq("arst_drops", 64'(o_err_drops), 64'd0);
    check_eq("arst_busy",  64'(o_busy),      64'd0);
    i_stb  = 1'b0;
    i_busy = 1'b0;
    @(negedge clk);
    i_reset = 1'b0;
    found = 0;
    for (int k = 1; k <= 40 && found == 0; k++) begin
      @(posedge clk); #1;
      if (o_stb) found = k;
    end
    check_eq("arst_idle_edge", 64'(found), 64'd17);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
